// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding one UART transmitter.
// An owner keeps the transmitter until its last byte or a stall timeout.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic [N_REQ-1:0]   grant,
    output logic               timeout_err
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
    localparam logic [PW:0]   N_WIDE   = (PW+1)'(N_REQ);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE} state_e;

    state_e           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [PW-1:0]    owner_q;
    logic [PW-1:0]    rr_ptr_q;
    logic [7:0]       tx_data_q;
    logic             tx_start_q;
    logic             last_q;
    logic             tmo_err_q;
    logic [TW-1:0]    tmo_cnt_q;

    logic [N_REQ-1:0] rot;
    logic [PW-1:0]    pick_off;
    logic [PW-1:0]    pick_idx;
    logic [PW:0]      pick_sum;
    logic [PW-1:0]    owner_nxt;
    logic             pick_ok;
    logic             own_valid;
    logic             xfer;
    logic             tmo_hit;

    // Rotate so bit 0 is the requester at rr_ptr; lowest set bit wins.
    assign rot = N_REQ'({req_valid, req_valid} >> rr_ptr_q);

    always_comb begin
        pick_ok  = 1'b0;
        pick_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick_ok  = 1'b1;
                pick_off = PW'(k);
            end
        end
    end

    assign pick_sum  = {1'b0, rr_ptr_q} + {1'b0, pick_off};
    assign pick_idx  = (pick_sum >= N_WIDE) ? PW'(pick_sum - N_WIDE)
                                            : pick_sum[PW-1:0];
    assign owner_nxt = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    assign own_valid = req_valid[owner_q];
    assign xfer      = (state_q == LOAD) && own_valid && !tx_busy;
    assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            last_q     <= 1'b0;
            tmo_err_q  <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            tx_start_q <= 1'b0;
            tmo_err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_ok) begin
                        grant_q   <= N_REQ'(1) << pick_idx;
                        owner_q   <= pick_idx;
                        tmo_cnt_q <= '0;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    // A transfer in the expiry cycle takes priority.
                    if (xfer) begin
                        tx_data_q  <= req_data[{owner_q, 3'b000} +: 8];
                        last_q     <= req_last[owner_q];
                        tx_start_q <= 1'b1;
                        tmo_cnt_q  <= '0;
                        state_q    <= WAIT_ACK;
                    end else if (tmo_hit) begin
                        grant_q   <= '0;
                        rr_ptr_q  <= owner_nxt;
                        tmo_err_q <= 1'b1;
                        state_q   <= IDLE;
                    end else if (!own_valid) begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (tx_busy) state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            grant_q  <= '0;
                            rr_ptr_q <= owner_nxt;
                            state_q  <= IDLE;
                        end else begin
                            tmo_cnt_q <= '0;
                            state_q   <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are forced quiet for the whole time rst is held.
    assign req_ready   = (!rst && state_q == LOAD && !tx_busy) ? grant_q : '0;
    assign tx_start    = tx_start_q & ~rst;
    assign timeout_err = tmo_err_q & ~rst;
    assign grant       = rst ? '0 : grant_q;
    assign tx_data     = rst ? '0 : tx_data_q;

endmodule
